// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: builds 32-bit instructions from a byte-wide shared
// memory port and presents them to decode via the IF/ID pipeline register.
//
// Interface contract with decode and the pipeline controller:
//   id_valid=1 marks id_pc/id_inst as a real instruction, and id_valid=0 is a bubble.
//   if_stall_req=1 means no complete instruction is buffered. The controller
//   answers with stall_cmd[0]=1, which holds the PC.
//   stall_cmd[1]=1 freezes the IF/ID register. An instruction leaves the fetch
//   buffer only on an enabled edge where state is READY and stall_cmd[1:0]=00.
//   mem_rd is a one-cycle byte request. Its data appears on mem_rdata in the
//   following cycle, and pend_q tracks that outstanding answer.
module if_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [4:0]        stall_cmd,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              mem_busy,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              if_stall_req,
  output logic [ADDR_W-1:0] id_pc,
  output logic [31:0]       id_inst,
  output logic              id_valid
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [2:0]        iss_q, iss_d;      // bytes requested for the current word
  logic [2:0]        rcv_q, rcv_d;      // bytes received for the current word
  logic              pend_q, pend_d;    // a request was issued last enabled cycle
  logic [31:0]       buf_q, buf_d;      // little-endian assembly buffer
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [31:0]       id_inst_q, id_inst_d;
  logic              id_valid_q, id_valid_d;

  // Address of the next byte. It is combinational, so it follows iss_q within the same cycle.
  assign mem_addr     = pc_q + ADDR_W'(iss_q);
  // The stall request looks only at state and rst, so there is no combinational path
  // back from stall_cmd through the controller.
  assign if_stall_req = (state_q == S_FETCH) && !rst;

  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;
  assign id_valid = id_valid_q;

  // Next-state logic. Priority is rst, then rdy low, then branch, then stall_cmd, then normal fetch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    iss_d      = iss_q;
    rcv_d      = rcv_q;
    pend_d     = pend_q;
    buf_d      = buf_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    mem_rd     = 1'b0;

    if (rst) begin
      state_d    = S_FETCH;
      pc_d       = RESET_PC;
      iss_d      = 3'd0;
      rcv_d      = 3'd0;
      pend_d     = 1'b0;
      id_pc_d    = '0;
      id_inst_d  = '0;
      id_valid_d = 1'b0;
    end else if (!rdy) begin
      // Frozen. Memory still answers the request from the last enabled cycle,
      // so that byte is kept. Clearing pend stops it from being taken twice.
      if (pend_q) begin
        buf_d[{rcv_q[1:0], 3'b000} +: 8] = mem_rdata;
        rcv_d  = rcv_q + 3'd1;
        pend_d = 1'b0;
      end
    end else if (branch_flag) begin
      // Redirect. Any partial or complete word is dropped, and the byte still
      // in flight is ignored because pend is cleared.
      state_d    = S_FETCH;
      pc_d       = branch_target;
      iss_d      = 3'd0;
      rcv_d      = 3'd0;
      pend_d     = 1'b0;
      id_pc_d    = '0;
      id_inst_d  = '0;
      id_valid_d = 1'b0;
    end else if (state_q == S_FETCH) begin
      // Issue side. Yield the port whenever the MEM stage owns it.
      if ((iss_q < 3'd4) && !mem_busy) begin
        mem_rd = 1'b1;
        iss_d  = iss_q + 3'd1;
        pend_d = 1'b1;
      end else begin
        pend_d = 1'b0;
      end
      // Receive side. The byte answering last cycle's request lands at lane rcv.
      if (pend_q) begin
        buf_d[{rcv_q[1:0], 3'b000} +: 8] = mem_rdata;
        rcv_d = rcv_q + 3'd1;
      end
      if (rcv_d == 3'd4) begin
        state_d = S_READY;
      end
      // Nothing is ready to hand over, so IF/ID bubbles unless it is held.
      if (!stall_cmd[1]) begin
        id_pc_d    = '0;
        id_inst_d  = '0;
        id_valid_d = 1'b0;
      end
    end else begin
      pend_d = 1'b0;
      if (stall_cmd[1]) begin
        // IF/ID is held, so the buffered word must not be consumed either.
      end else if (stall_cmd[0]) begin
        id_pc_d    = '0;
        id_inst_d  = '0;
        id_valid_d = 1'b0;
      end else begin
        id_pc_d    = pc_q;
        id_inst_d  = buf_q;
        id_valid_d = 1'b1;
        pc_d       = pc_q + ADDR_W'(4);
        iss_d      = 3'd0;
        rcv_d      = 3'd0;
        state_d    = S_FETCH;
      end
    end
  end

  // State registers. Reset is applied through the next-state logic, so it is synchronous.
  always_ff @(posedge clk) begin
    state_q    <= state_d;
    pc_q       <= pc_d;
    iss_q      <= iss_d;
    rcv_q      <= rcv_d;
    pend_q     <= pend_d;
    buf_q      <= buf_d;
    id_pc_q    <= id_pc_d;
    id_inst_q  <= id_inst_d;
    id_valid_q <= id_valid_d;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage for the 5-stage RISC-V core, and the consumer of the stall command bus produced by the pipeline controller. It assembles 32-bit instructions from the byte-wide shared memory port. It raises if_stall_req while no instruction is ready, and drives the IF/ID pipeline register. It obeys stall_cmd hold/bubble semantics and EX-stage branch redirects.

Parameters:
RESET_PC, 32'h00000000, PC loaded on reset
ADDR_W, 32, address width of PC and memory port

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
rdy  input  1  global enable; low freezes all state
stall_cmd  input  5  bit0 stall PC/IF, bit1 stall IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB
branch_flag  input  1  one-cycle redirect pulse from EX
branch_target  input  32  redirect PC
mem_busy  input  1  memory port owned by MEM stage this cycle
mem_rd  output  1  byte read request
mem_addr  output  32  byte address
mem_rdata  input  8  read data, valid the cycle after a request
if_stall_req  output  1  no complete instruction available
id_pc  output  32  IF/ID register: instruction PC
id_inst  output  32  IF/ID register: instruction word
id_valid  output  1  IF/ID register: 0 = bubble

Behaviour:
- Priority is rst > rdy low > branch_flag > stall_cmd > normal fetch.
- Reset values: pc=RESET_PC, id_pc=0, id_inst=0, id_valid=0, issue counter iss=0, receive counter rcv=0, pend=0, state FETCH. Outputs after reset: mem_rd=0, if_stall_req=1.
- When rdy=0: no register changes, mem_rd=0. Any byte returned in that cycle is still captured if pend=1, because memory answers the previous request.
- States: FETCH and READY.
- FETCH, issue side:
  - If iss<4 and mem_busy=0: mem_rd=1, mem_addr=pc+iss, iss++, pend<=1.
  - Otherwise: mem_rd=0, pend<=0.
  - mem_addr is combinational.
- FETCH, receive side:
  - If pend=1: buf[8*rcv+:8]<=mem_rdata, rcv++.
  - When rcv reaches 4, go to READY.
  - Byte order is little-endian: inst[7:0] is the byte at pc.
- READY: mem_rd=0, if_stall_req=0, buffer held.
  - Hand-off happens at the edge where stall_cmd[0]=0: id_pc<=pc, id_inst<=buf, id_valid<=1, pc<=pc+4, iss=rcv=0, go to FETCH.
- if_stall_req = (state==FETCH) && !rst, combinational. It does not depend on stall_cmd, so there is no loop through the controller.
- IF/ID register rules, evaluated every enabled edge:
  - stall_cmd[1]=1: hold id_* registers.
  - stall_cmd[0]=1 and stall_cmd[1]=0: bubble, id_valid<=0, id_inst<=0, id_pc<=0.
  - stall_cmd[0]=0 and state READY: hand-off as above.
  - stall_cmd[0]=0 and state FETCH: bubble. The controller normally prevents this because if_stall_req forces stall_cmd[0].
- PC holds whenever stall_cmd[0]=1.
- branch_flag=1, regardless of stall_cmd or state:
  - pc<=branch_target, state FETCH, iss=rcv=0, pend<=0, mem_rd=0 this cycle.
  - IF/ID becomes a bubble.
  - The byte returned the next cycle is discarded, because pend=0.
  - A READY buffer is dropped.
- Latency from the first enabled cycle (C0) after reset or branch, with mem_busy=0:
  - Requests in C0..C3, bytes captured at the ends of C1..C4.
  - READY in C5; hand-off at the end of C5, so id_valid=1 in C6.
  - Throughput is 1 instruction per 6 cycles. Each mem_busy cycle adds one cycle.
- Arithmetic: pc+iss and pc+4 wrap modulo 2^32. No alignment check.

Test Plan:
- Reset, then rst=0, memory 0x0..0x3 = 13,05,10,00, stall_cmd driven as controller (00001 while if_stall_req) -> mem_addr 0,1,2,3 in C0..C3; if_stall_req falls in C5; in C6 id_pc=0, id_inst=32'h00100513, id_valid=1; next fetch starts at addr 4.
- mem_busy=1 during C1..C2 -> addresses 0,(none),(none),1,2,3 in C0..C5; inst still 32'h00100513; id_valid rises 2 cycles later (C8).
- READY with stall_cmd=00011 for 3 cycles, then 00000 -> id_* held unchanged and buffer and pc held; hand-off on the first 00000 edge, pc advances by exactly 4.
- branch_flag pulse with branch_target=0x100 in C2 of a fetch at pc=0x8 -> mem_rd=0 in C2; the C3 returned byte is ignored; requests 0x100..0x103 follow; id_valid=0 next edge; resulting id_pc=0x100.
- rdy=0 for 4 cycles mid-fetch (iss=2) -> mem_rd=0, iss/rcv/pc/id_* frozen; resumes with mem_addr=pc+2; assembled word correct.
- rst=1 while READY with id_valid=1 -> next cycle pc=RESET_PC, id_valid=0, id_inst=0, if_stall_req=0 while rst is high, then 1 after release.
